// File: rtl/control_unit_legv8.sv
// Multi-cycle LEGv8 control sequencer: fetch, decode, execute and memory phases.
// Build option: define ILLEGAL_HALT_EN to halt on an undefined opcode instead of a NOP.
module control_unit_legv8 (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] CONSIG,
    input  logic [3:0]  STAT,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        WR,
    output logic        IR,
    output logic [4:0]  FS,
    output logic        C0,
    output logic [63:0] K,
    output logic        M,
    output logic        PC_SEL,
    output logic [1:0]  PS,
    output logic        EN_ALU,
    output logic        EN_B,
    output logic        EN_PC,
    output logic        EN_ADDR_ALU,
    output logic        EN_ADDR_PC,
    output logic        RCS,
    output logic        RWE,
    output logic        ROE,
    output logic        HALTED
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [5:0]  OP_B    = 6'h05;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00001;
    localparam logic [4:0] FS_ADD = 5'b00010;
    localparam logic [4:0] FS_SUB = 5'b01010;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b11;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        EXEC   = 3'd2,
        MEM1   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [REG_W-1:0] rd, rn, rm;
    logic [XLEN-1:0]  imm12_k, imm9_k, imm19_k, imm26_k;
    logic [10:0]      op11;
    logic [9:0]       op10;
    logic [5:0]       op6;
    logic [7:0]       op8;
    logic             zero;
    logic             unused_stat;

    assign rd      = CONSIG[4:0];
    assign rn      = CONSIG[9:5];
    assign rm      = CONSIG[20:16];
    assign imm12_k = XLEN'(CONSIG[21:10]);
    assign imm9_k  = {{55{CONSIG[20]}}, CONSIG[20:12]};
    assign imm19_k = {{45{CONSIG[23]}}, CONSIG[23:5]};
    assign imm26_k = {{38{CONSIG[25]}}, CONSIG[25:0]};
    assign op11    = CONSIG[31:21];
    assign op10    = CONSIG[31:22];
    assign op6     = CONSIG[31:26];
    assign op8     = CONSIG[31:24];
    assign zero    = STAT[0];
    assign unused_stat = ^STAT[3:1];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= FETCH0;
        else     state <= state_nxt;
    end

    // Next state and control outputs; everything idles at 0 while RST is high
    always_comb begin
        state_nxt   = state;
        SA          = '0;
        SB          = '0;
        DA          = '0;
        WR          = 1'b0;
        IR          = 1'b0;
        FS          = '0;
        C0          = 1'b0;
        K           = '0;
        M           = 1'b0;
        PC_SEL      = 1'b0;
        PS          = PS_HOLD;
        EN_ALU      = 1'b0;
        EN_B        = 1'b0;
        EN_PC       = 1'b0;
        EN_ADDR_ALU = 1'b0;
        EN_ADDR_PC  = 1'b0;
        RCS         = 1'b0;
        RWE         = 1'b0;
        ROE         = 1'b0;
        HALTED      = 1'b0;

        if (RST) begin
            state_nxt = FETCH0;
        end else begin
            case (state)
                FETCH0: begin
                    EN_ADDR_PC = 1'b1;
                    RCS        = 1'b1;
                    ROE        = 1'b1;
                    state_nxt  = FETCH1;
                end
                FETCH1: begin
                    EN_ADDR_PC = 1'b1;
                    RCS        = 1'b1;
                    ROE        = 1'b1;
                    IR         = 1'b1;
                    state_nxt  = EXEC;
                end
                EXEC: begin
                    state_nxt = FETCH0;
                    if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
                        SA     = rn;
                        SB     = rm;
                        DA     = rd;
                        M      = 1'b1;
                        EN_ALU = 1'b1;
                        WR     = 1'b1;
                        PS     = PS_INC;
                        case (op11)
                            OP_SUB:  begin FS = FS_SUB; C0 = 1'b1; end
                            OP_AND:  FS = FS_AND;
                            OP_ORR:  FS = FS_ORR;
                            default: FS = FS_ADD;
                        endcase
                    end else if (op11 == OP_LDUR) begin
                        SA          = rn;
                        K           = imm9_k;
                        FS          = FS_ADD;
                        EN_ADDR_ALU = 1'b1;
                        RCS         = 1'b1;
                        ROE         = 1'b1;
                        state_nxt   = MEM1;
                    end else if (op11 == OP_STUR) begin
                        SA          = rn;
                        SB          = rd;
                        K           = imm9_k;
                        FS          = FS_ADD;
                        EN_ADDR_ALU = 1'b1;
                        EN_B        = 1'b1;
                        RCS         = 1'b1;
                        RWE         = 1'b1;
                        PS          = PS_INC;
                    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
                        SA     = rn;
                        SB     = rm;
                        DA     = rd;
                        K      = imm12_k;
                        EN_ALU = 1'b1;
                        WR     = 1'b1;
                        PS     = PS_INC;
                        if (op10 == OP_SUBI) begin
                            FS = FS_SUB;
                            C0 = 1'b1;
                        end else begin
                            FS = FS_ADD;
                        end
                    end else if (op6 == OP_B) begin
                        K  = imm26_k;
                        PS = PS_REL;
                    end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
                        // XZR | Rt sets Z from the register while K carries the branch offset
                        SA = XZR;
                        SB = rd;
                        M  = 1'b1;
                        FS = FS_ORR;
                        if (zero == (op8 == OP_CBZ)) begin
                            K  = imm19_k;
                            PS = PS_REL;
                        end else begin
                            PS = PS_INC;
                        end
                    end else begin
`ifdef ILLEGAL_HALT_EN
                        state_nxt = HALT;
`else
                        PS = PS_INC;
`endif
                    end
                end
                MEM1: begin
                    SA          = rn;
                    K           = imm9_k;
                    FS          = FS_ADD;
                    EN_ADDR_ALU = 1'b1;
                    RCS         = 1'b1;
                    ROE         = 1'b1;
                    DA          = rd;
                    WR          = 1'b1;
                    PS          = PS_INC;
                    state_nxt   = FETCH0;
                end
                HALT: begin
`ifdef ILLEGAL_HALT_EN
                    HALTED    = 1'b1;
                    state_nxt = HALT;
`else
                    state_nxt = FETCH0;
`endif
                end
                default: state_nxt = FETCH0;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit_legv8.sv
// Self-checking bench for control_unit_legv8: per-instruction phase model plus literal pins.
module tb_control_unit_legv8;

`ifdef ILLEGAL_HALT_EN
    localparam bit HALT_BUILD = 1'b1;
`else
    localparam bit HALT_BUILD = 1'b0;
`endif

    typedef enum int {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR, K_STUR,
                      K_B, K_CBZ, K_CBNZ, K_ILL} kind_e;

    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        wr;
        logic        ir;
        logic [4:0]  fs;
        logic        c0;
        logic [63:0] k;
        logic        m;
        logic        pc_sel;
        logic [1:0]  ps;
        logic        en_alu;
        logic        en_b;
        logic        en_pc;
        logic        en_addr_alu;
        logic        en_addr_pc;
        logic        rcs;
        logic        rwe;
        logic        roe;
        logic        halted;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] consig = '0;
    logic [3:0]  stat = '0;
    outs_t       dut_o;

    control_unit_legv8 u_dut (
        .CLK(clk), .RST(rst), .CONSIG(consig), .STAT(stat),
        .SA(dut_o.sa), .SB(dut_o.sb), .DA(dut_o.da), .WR(dut_o.wr), .IR(dut_o.ir),
        .FS(dut_o.fs), .C0(dut_o.c0), .K(dut_o.k), .M(dut_o.m), .PC_SEL(dut_o.pc_sel),
        .PS(dut_o.ps), .EN_ALU(dut_o.en_alu), .EN_B(dut_o.en_b), .EN_PC(dut_o.en_pc),
        .EN_ADDR_ALU(dut_o.en_addr_alu), .EN_ADDR_PC(dut_o.en_addr_pc),
        .RCS(dut_o.rcs), .RWE(dut_o.rwe), .ROE(dut_o.roe), .HALTED(dut_o.halted)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    bit    chk_en = 1'b0;
    int    ph = 0;
    kind_e kind = K_ADD;
    bit    lit_en = 1'b0;
    logic [63:0] lit_k = '0;
    logic [1:0]  lit_ps = '0;

    function automatic int instr_len(kind_e kd);
        return (kd == K_LDUR) ? 4 : 3;
    endfunction

    // Expected outputs for a given phase of an instruction, from the architectural rules
    function automatic outs_t model(bit r, int p, kind_e kd, logic [31:0] ins, bit z);
        outs_t o;
        logic [4:0] f_rd, f_rn, f_rm;
        longint imm9, imm19, imm26;
        bit taken;
        o = '0;
        f_rd  = ins[4:0];
        f_rn  = ins[9:5];
        f_rm  = ins[20:16];
        imm9  = longint'($signed(ins[20:12]));
        imm19 = longint'($signed(ins[23:5]));
        imm26 = longint'($signed(ins[25:0]));
        if (r) return o;
        if (p < 2) begin
            o.en_addr_pc = 1'b1; o.rcs = 1'b1; o.roe = 1'b1;
            o.ir = (p == 1);
            return o;
        end
        if (p == 3 && kd == K_ILL) begin
            o.halted = 1'b1;
            return o;
        end
        if (p == 3) begin
            o.sa = f_rn; o.k = 64'(imm9); o.fs = 5'd2;
            o.en_addr_alu = 1'b1; o.rcs = 1'b1; o.roe = 1'b1;
            o.da = f_rd; o.wr = 1'b1; o.ps = 2'd1;
            return o;
        end
        case (kd)
            K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI: begin
                o.sa = f_rn; o.sb = f_rm; o.da = f_rd;
                o.en_alu = 1'b1; o.wr = 1'b1; o.ps = 2'd1;
                o.m = (kd == K_ADD || kd == K_SUB || kd == K_AND || kd == K_ORR);
                if (!o.m) o.k = {52'd0, ins[21:10]};
                case (kd)
                    K_AND:         o.fs = 5'd0;
                    K_ORR:         o.fs = 5'd1;
                    K_SUB, K_SUBI: begin o.fs = 5'd10; o.c0 = 1'b1; end
                    default:       o.fs = 5'd2;
                endcase
            end
            K_LDUR: begin
                o.sa = f_rn; o.k = 64'(imm9); o.fs = 5'd2;
                o.en_addr_alu = 1'b1; o.rcs = 1'b1; o.roe = 1'b1;
            end
            K_STUR: begin
                o.sa = f_rn; o.sb = f_rd; o.k = 64'(imm9); o.fs = 5'd2;
                o.en_addr_alu = 1'b1; o.en_b = 1'b1; o.rcs = 1'b1; o.rwe = 1'b1; o.ps = 2'd1;
            end
            K_B: begin
                o.k = 64'(imm26); o.ps = 2'd3;
            end
            K_CBZ, K_CBNZ: begin
                o.sa = 5'd31; o.sb = f_rd; o.m = 1'b1; o.fs = 5'd1;
                taken = (kd == K_CBZ) ? z : !z;
                if (taken) begin o.k = 64'(imm19); o.ps = 2'd3; end
                else       o.ps = 2'd1;
            end
            default: o.ps = HALT_BUILD ? 2'd0 : 2'd1;
        endcase
        return o;
    endfunction

    // Model phase within the current instruction
    always @(posedge clk) begin
        if (rst)                                  ph <= 0;
        else if (kind == K_ILL && HALT_BUILD && ph >= 2) ph <= 3;
        else if (ph + 1 == instr_len(kind))       ph <= 0;
        else                                      ph <= ph + 1;
    end

    // Compare process, mid-cycle
    always @(negedge clk) begin
        outs_t exp_o;
        int drivers;
        if (chk_en) begin
            exp_o = model(rst, ph, kind, consig, stat[0]);
            checks++;
            if (dut_o !== exp_o) begin
                failures++;
                $display("FAIL outputs ph=%0d kind=%0d ins=%h got=%h exp=%h", ph, kind, consig, dut_o, exp_o);
            end
            drivers = int'(dut_o.en_alu) + int'(dut_o.en_b) + int'(dut_o.en_pc) +
                      int'(dut_o.rcs & dut_o.roe & !dut_o.rwe);
            checks++;
            if (drivers > 1 || (dut_o.en_addr_alu && dut_o.en_addr_pc)) begin
                failures++;
                $display("FAIL bus_owner drivers=%0d addr_alu=%b addr_pc=%b required <=1 and not both",
                         drivers, dut_o.en_addr_alu, dut_o.en_addr_pc);
            end
            if (rst) begin
                checks++;
                if (dut_o !== '0) begin
                    failures++;
                    $display("FAIL reset_zero got=%h required 0", dut_o);
                end
            end else if (ph == 0) begin
                checks++;
                if ({dut_o.en_addr_pc, dut_o.rcs, dut_o.roe, dut_o.ir} !== 4'b1110) begin
                    failures++;
                    $display("FAIL fetch0_pin got=%b required 1110",
                             {dut_o.en_addr_pc, dut_o.rcs, dut_o.roe, dut_o.ir});
                end
            end else if (ph == 2 && lit_en) begin
                checks++;
                if (dut_o.k !== lit_k || dut_o.ps !== lit_ps) begin
                    failures++;
                    $display("FAIL exec_pin ins=%h got K=%h PS=%b required K=%h PS=%b",
                             consig, dut_o.k, dut_o.ps, lit_k, lit_ps);
                end
            end else if (ph == 3 && kind == K_ILL) begin
                checks++;
                if (dut_o.halted !== 1'b1 || dut_o.ps !== 2'b00) begin
                    failures++;
                    $display("FAIL halt_pin got HALTED=%b PS=%b required 1/00", dut_o.halted, dut_o.ps);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] ins;
        kind_e       kd;
        bit          z;
        logic [63:0] k;
        logic [1:0]  ps;
    } vec_t;

    vec_t vecs[$];

    task automatic load(input vec_t v);
        consig = v.ins;
        kind   = v.kd;
        stat   = {3'b101, v.z};
        lit_k  = v.k;
        lit_ps = v.ps;
        lit_en = 1'b1;
    endtask

    task automatic run(input vec_t v);
        load(v);
        repeat (instr_len(v.kd)) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t ill;
        vecs.push_back('{32'h8B020023, K_ADD,  1'b0, 64'h0, 2'b01});
        vecs.push_back('{32'hD1000484, K_SUBI, 1'b0, 64'h1, 2'b01});
        vecs.push_back('{32'hF85F80C5, K_LDUR, 1'b0, 64'hFFFFFFFFFFFFFFF8, 2'b00});
        vecs.push_back('{32'hB4000067, K_CBZ,  1'b1, 64'h3, 2'b11});
        vecs.push_back('{32'hB4000067, K_CBZ,  1'b0, 64'h0, 2'b01});
        vecs.push_back('{32'h17FFFFFE, K_B,    1'b0, 64'hFFFFFFFFFFFFFFFE, 2'b11});
        vecs.push_back('{32'hCB0B0149, K_SUB,  1'b0, 64'h0, 2'b01});
        vecs.push_back('{32'h8A030041, K_AND,  1'b1, 64'h0, 2'b01});
        vecs.push_back('{32'hAA0700C5, K_ORR,  1'b0, 64'h0, 2'b01});
        vecs.push_back('{32'h913FFC62, K_ADDI, 1'b0, 64'hFFF, 2'b01});
        vecs.push_back('{32'hF80FF128, K_STUR, 1'b0, 64'hFF, 2'b01});
        vecs.push_back('{32'hB5FFFFE2, K_CBNZ, 1'b0, 64'hFFFFFFFFFFFFFFFF, 2'b11});
        vecs.push_back('{32'hB5FFFFE2, K_CBNZ, 1'b1, 64'h0, 2'b01});

        rst = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // Reset during LDUR's EXEC abandons it and restarts at FETCH0
        load(vecs[2]);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run(vecs[0]);

        ill = '{32'hFFFFFFFF, K_ILL, 1'b0, 64'h0, HALT_BUILD ? 2'b00 : 2'b01};
        if (HALT_BUILD) begin
            load(ill);
            repeat (13) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            run(ill);
        end
        run(vecs[0]);
        run(vecs[3]);

        chk_en = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit_legv8.md
# control_unit_legv8

Multi-cycle control sequencer that drives every control input of the LEGv8 datapath and consumes its `CONSIG` (instruction register) and `STAT` outputs. It fetches an instruction from RAM into the instruction register, decodes it, and sequences execute and memory phases. The supported subset is ADD, SUB, AND, ORR, ADDI, SUBI, LDUR, STUR, B, CBZ and CBNZ. It sits beside the datapath in the CPU top level; the datapath has no other source of control.

## Interface
- No parameters.
- `CLK` in 1: system clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `CONSIG` in 32: current instruction from the datapath instruction register.
- `STAT` in 4: ALU status {V,C,N,Z}; `STAT[0]`=Z.
- `SA`, `SB`, `DA` out 5 each: register-file A select, B select, write select.
- `WR` out 1: register-file write enable.
- `IR` out 1: instruction register load.
- `FS` out 5, `C0` out 1: ALU function and carry-in.
- `K` out 64: constant.
- `M` out 1: ALU B-input mux select; 0 selects `K`, 1 selects the register B value.
- `PC_SEL` out 1: PC input select; 0 selects ABUS, 1 selects `K`.
- `PS` out 2: PC op; 00 hold, 01 PC+4, 10 load, 11 PC+(K<<2).
- `EN_ALU`, `EN_B`, `EN_PC` out 1 each: DBUS drivers.
- `EN_ADDR_ALU`, `EN_ADDR_PC` out 1 each: RAM address drivers.
- `RCS`, `RWE`, `ROE` out 1 each: RAM chip select, write enable, output enable.
- `HALTED` out 1: high in HALT state.

## Operation
- **Field decode:**
  - Rd/Rt = `CONSIG[4:0]`, Rn = `[9:5]`, Rm = `[20:16]`.
  - imm12 = `[21:10]`, zero-extended.
  - imm9 = `[20:12]`, imm19 = `[23:5]`, imm26 = `[25:0]`, each sign-extended to 64 bits.
- **Opcodes:**
  - 11-bit `[31:21]`: ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550, LDUR 0x7C2, STUR 0x7C0.
  - 10-bit `[31:22]`: ADDI 0x244, SUBI 0x344.
  - `[31:26]`: B 0x05.
  - `[31:24]`: CBZ 0xB4, CBNZ 0xB5.
- **FS/C0:**
  - AND 00000/0; ORR 00001/0; ADD 00010/0.
  - SUB 01010/1 (invert B, carry in).
- **States:** FETCH0, FETCH1, EXEC, MEM1, HALT. State register resets to FETCH0.
- **Default for all outputs:** 0, unless a state below asserts them.
- **FETCH0:** `EN_ADDR_PC`=1, `RCS`=1, `ROE`=1, `PS`=00. Next state FETCH1.
- **FETCH1:** same address and RAM enables as FETCH0, plus `IR`=1; IR captures DBUS at the edge. Next state EXEC.
- **EXEC, R-type:** `SA`=Rn, `SB`=Rm, `DA`=Rd, `M`=1, `EN_ALU`=1, `WR`=1, `PS`=01. Next state FETCH0.
- **EXEC, I-type:** as R-type but `M`=0 and `K`=imm12.
- **EXEC, LDUR:** `SA`=Rn, `M`=0, `K`=imm9, `FS`=ADD, `EN_ADDR_ALU`=1, `RCS`=1, `ROE`=1. Next state MEM1.
- **MEM1:** same address and RAM enables as EXEC LDUR, plus `DA`=Rt, `WR`=1, `PS`=01. Next state FETCH0.
- **EXEC, STUR:** `SA`=Rn, `SB`=Rt, `M`=0, `K`=imm9, `FS`=ADD, `EN_ADDR_ALU`=1, `EN_B`=1, `RCS`=1, `RWE`=1, `PS`=01. Next state FETCH0.
- **EXEC, B:** `K`=imm26, `PS`=11. Next state FETCH0.
- **EXEC, CBZ/CBNZ:**
  - Drive `SA`=Rt, `M`=0, `K`=0, `FS`=ADD; Z is valid combinationally in the same cycle.
  - Branch is taken when Z=1 (CBZ) or Z=0 (CBNZ).
  - Taken: `K`=imm19, `PS`=11. Not taken: `PS`=01.
  - `K` is muxed: it carries the compare zero through the ALU and the offset to the PC. `M`=0 feeds `K` to the ALU; this use is decided.
  - Implementation: assert the ALU compare using `SB`=Rt, `M`=1, `FS`=ORR with `SA`=31 (XZR), so `K` is free for the offset.
- **EXEC, undefined opcode:** behaviour is set by `ILLEGAL_HALT_EN` (see Configuration).
- **DBUS ownership:** at most one DBUS driver per cycle, where the drivers are `EN_ALU`, `EN_B`, `EN_PC` and the RAM read (`RCS`&`ROE`&!`RWE`). `EN_ADDR_ALU` and `EN_ADDR_PC` are never both 1.
- **PC:** the PC holds the current instruction address until EXEC or MEM1 issues `PS`=01 or 11. Branch offsets are therefore relative to the branch's own address.

## Timing
- **While `RST`=1:** all outputs are 0 and `HALTED`=0. The first cycle after `RST` falls is FETCH0.
- **Outputs:** combinational from state, `CONSIG` and `STAT`. All state changes occur on the rising edge of `CLK`.
- **Cycles per instruction:** ALU ops, STUR, B, CBZ and CBNZ take 3 cycles. LDUR takes 4 cycles.
- **RAM reads:** synchronous. Address and enables are held for 2 cycles, and data is valid on DBUS in the second cycle.
- **Reset mid-instruction:** `RST` asserted in any state returns to FETCH0 on the next edge. Any partial instruction has no further effect.

## Configuration
- **`ILLEGAL_HALT_EN` defined:**
  - An undefined opcode in EXEC moves to HALT.
  - HALT drives `PS`=00, all enables 0 and `HALTED`=1.
  - Only `RST` leaves HALT.
- **`ILLEGAL_HALT_EN` undefined:**
  - An undefined opcode executes as a NOP: `PS`=01, next state FETCH0.
  - The HALT state is unreachable and `HALTED` is tied to 0.

## Test plan
- **Reset, then fetch:** `RST` for 2 cycles → all outputs 0. Then FETCH0 shows `EN_ADDR_PC`=1/`RCS`=1/`ROE`=1, and FETCH1 shows `IR`=1.
- **ADD X3,X1,X2** (`CONSIG`=0x8B020023) → in EXEC: `SA`=1, `SB`=2, `DA`=3, `FS`=00010, `M`=1, `WR`=1, `EN_ALU`=1, `PS`=01. 3 cycles total.
- **SUBI X4,X4,#1** (0xD1000484) → `FS`=01010, `C0`=1, `M`=0, `K`=1, `DA`=4.
- **LDUR X5,[X6,#-8]** (0xF85F80C5) → `K`=0xFFFFFFFFFFFFFFF8, `EN_ADDR_ALU`=1 for 2 cycles; `WR`=1 and `DA`=5 only in MEM1. 4 cycles total.
- **CBZ X7,#+3** (0xB4000067):
  - `STAT[0]`=1 → `PS`=11, `K`=3.
  - `STAT[0]`=0 → `PS`=01.
  - **B #-2** (0x17FFFFFE) → `K`=0xFFFFFFFFFFFFFFFE, `PS`=11.
- **`CONSIG`=0xFFFFFFFF:**
  - With `ILLEGAL_HALT_EN` defined → `HALTED`=1 and held for 10 cycles, `PS`=00. Asserting `RST` returns to FETCH0.
  - Without `ILLEGAL_HALT_EN` → `PS`=01, then FETCH0.
